// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and constants for the 2-bit decoder scan-code generator.
// The BLANK state is only reached when SCAN_BLANK_EN is defined.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    localparam int CODE_W = 2;

    localparam logic [CODE_W-1:0] CODE_UP_LAST = 2'd3;
    localparam logic [CODE_W-1:0] CODE_DN_LAST = 2'd0;

    // Modulo-4 step; wraps naturally through the 2-bit width.
    function automatic logic [CODE_W-1:0] code_step(input logic [CODE_W-1:0] code,
                                                     input logic             down);
        logic [CODE_W-1:0] w_next;
        if (down) begin
            w_next = code - 2'd1;
        end else begin
            w_next = code + 2'd1;
        end
        return w_next;
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_prescaler.sv
// Dwell prescaler: counts 0..div while enabled and flags the terminal count.
// The tick is a same-cycle decode so the FSM can step on the last dwell cycle.
module scan_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = en && (r_cnt == div);

    // Prescale counter; clears on terminal count so it never exceeds div.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + DIV_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan-code generator driving the 2-to-4 decoder select pair y1/y2.
// Optional feature macro: SCAN_BLANK_EN inserts a one-cycle blank after every code step.
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             single,
    input  logic [DIV_W-1:0] div,
    output logic             y1,
    output logic             y2,
    output logic             code_valid,
    output logic             wrap,
    output logic             busy
);

    scan_state_e       r_state;
    scan_state_e       w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_wrap;
    logic              w_wrap_nxt;
    logic              r_busy;
    logic              r_dir;
    logic              r_single;
    logic [DIV_W-1:0]  r_div;
    logic              w_latch;
    logic              w_clr;
    logic              w_tick;
    logic              w_run;
    logic [CODE_W-1:0] w_last;

    assign w_run  = (r_state == ST_RUN);
    assign w_last = r_dir ? CODE_DN_LAST : CODE_UP_LAST;

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .en    (w_run),
        .div   (r_div),
        .tick  (w_tick)
    );

    // Next-state and next-output decode; stop overrides start and tick.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_wrap_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_clr       = 1'b0;
        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_latch     = 1'b1;
                        w_clr       = 1'b1;
                        w_code_nxt  = dir ? CODE_UP_LAST : CODE_DN_LAST;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_tick && r_single && (r_code == w_last)) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                    end else if (w_tick) begin
                        w_code_nxt = code_step(r_code, r_dir);
                        w_wrap_nxt = (r_code == w_last);
`ifdef SCAN_BLANK_EN
                        w_state_nxt = ST_BLANK;
                        w_valid_nxt = 1'b0;
`else
                        w_state_nxt = ST_RUN;
`endif
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
`ifdef SCAN_BLANK_EN
                ST_BLANK: begin
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b1;
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State, code and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= 2'b00;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Scan parameters captured at start; live input changes are ignored mid-scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir    <= 1'b0;
            r_single <= 1'b0;
            r_div    <= '0;
        end else if (w_latch) begin
            r_dir    <= dir;
            r_single <= single;
            r_div    <= div;
        end else begin
            r_dir    <= r_dir;
            r_single <= r_single;
            r_div    <= r_div;
        end
    end

    assign y1         = r_code[1];
    assign y2         = r_code[0];
    assign code_valid = r_valid;
    assign wrap       = r_wrap;
    assign busy       = r_busy;

endmodule
